// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// State encoding, owner ids, default widths and the read mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;

  localparam logic [3:0] MASK_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb2_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// req[0]=IFU, req[1]=LSU; last_grant is held by the caller; en gates grants.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = OWN_IFU;
    if (en) begin
      case (req)
        2'b01: begin
          gnt_id = OWN_IFU;
          gnt    = 2'b01;
        end
        2'b10: begin
          gnt_id = OWN_LSU;
          gnt    = 2'b10;
        end
        2'b11: begin
          // Tie: whoever did not win last time.
          gnt_id = ~last_grant;
          gnt    = last_grant ? 2'b01 : 2'b10;
        end
        default: begin
          gnt    = 2'b00;
          gnt_id = OWN_IFU;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_arb2.sv
// Arbitrates one memory port between IFU and LSU, one transaction at a time.
// Ports: ifu_*/lsu_* request+response, mem_* memory side, bus_err/err_owner timeout flags.
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_mask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic              err_owner
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_d;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             cnt_hit;
  logic             accept;

  rr_arb2 u_rr (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign accept  = |gnt;
  // The WAIT cycle in which the count reaches TIMEOUT.
  assign cnt_hit = (cnt == TO_LAST);

  assign ifu_req_ready  = gnt[0];
  assign lsu_req_ready  = gnt[1];
  assign mem_req_valid  = (state == REQ);
  assign ifu_resp_valid = (state == RESP) && (owner == OWN_IFU);
  assign lsu_resp_valid = (state == RESP) && (owner == OWN_LSU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid || cnt_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_LSU;
      owner      <= OWN_IFU;
      cnt        <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mask   <= MASK_NONE;
      ifu_rdata  <= '0;
      lsu_rdata  <= '0;
      bus_err    <= 1'b0;
      err_owner  <= OWN_IFU;
    end else begin
      if (state == IDLE && accept) begin
        owner      <= gnt_id;
        last_grant <= gnt_id;
        if (gnt_id == OWN_LSU) begin
          mem_addr  <= lsu_addr;
          mem_wen   <= lsu_wen;
          mem_wdata <= lsu_wdata;
          mem_mask  <= lsu_wen ? lsu_mask : MASK_NONE;
        end else begin
          mem_addr  <= ifu_addr;
          mem_wen   <= 1'b0;
          mem_wdata <= '0;
          mem_mask  <= MASK_NONE;
        end
      end
      if (state == REQ && mem_req_ready) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT) begin
        // A response in the timeout cycle still wins.
        if (mem_resp_valid) begin
          if (owner == OWN_LSU) lsu_rdata <= mem_rdata;
          else                  ifu_rdata <= mem_rdata;
        end else if (cnt_hit) begin
          if (owner == OWN_LSU) lsu_rdata <= '0;
          else                  ifu_rdata <= '0;
          bus_err   <= 1'b1;
          err_owner <= owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arb2;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 0, ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid = 0, lsu_req_ready;
  logic          lsu_wen = 0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [3:0]    lsu_mask = '0;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid, mem_req_ready = 0;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_mask;
  logic          mem_resp_valid = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic          bus_err, err_owner;

  mem_arb2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_mask(lsu_mask), .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .bus_err(bus_err), .err_owner(err_owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: one in-flight transaction, its owner,
  // whether memory took it, how long it has waited, and a pending pulse.
  bit            m_busy, m_taken, m_done;
  bit            m_own, m_last, m_err, m_eown;
  int            m_wait;
  logic [AW-1:0] m_addr;
  bit            m_wen;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_mask;
  logic [DW-1:0] m_rd [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_taken = 0; m_done = 0;
    m_own = 0; m_last = 1; m_err = 0; m_eown = 0;
    m_wait = 0; m_addr = '0; m_wen = 0; m_wdata = '0; m_mask = '0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ifu_rdy"}, {31'd0, ifu_req_ready}, 0);
    chk({nm, "_lsu_rdy"}, {31'd0, lsu_req_ready}, 0);
    chk({nm, "_ifu_rv"}, {31'd0, ifu_resp_valid}, 0);
    chk({nm, "_lsu_rv"}, {31'd0, lsu_resp_valid}, 0);
    chk({nm, "_mreq"}, {31'd0, mem_req_valid}, 0);
    chk({nm, "_mem_f"}, {mem_addr, 3'd0, mem_wen, mem_mask}, 0);
    chk({nm, "_mwdata"}, mem_wdata, 0);
    chk({nm, "_ifu_rd"}, ifu_rdata, 0);
    chk({nm, "_lsu_rd"}, lsu_rdata, 0);
    chk({nm, "_err"}, {30'd0, bus_err, err_owner}, 0);
  endtask

  task automatic drive_zero();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '0;
    lsu_wdata = '0; lsu_mask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    drive_zero();
    rst = 1;
    @(posedge clk);
    #1;
    if (check) chk_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, then
  // advance the model by what the next rising edge must do.
  task automatic cyc(input bit iv, input logic [AW-1:0] ia,
                     input bit lv, input bit lw,
                     input logic [AW-1:0] la, input logic [DW-1:0] wd,
                     input logic [3:0] mk, input bit mrr,
                     input bit mrv, input logic [DW-1:0] mrd);
    bit gi, gl, emv;
    @(negedge clk);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_wen = lw; lsu_addr = la;
    lsu_wdata = wd; lsu_mask = mk;
    mem_req_ready = mrr; mem_resp_valid = mrv; mem_rdata = mrd;
    #1;
    gi  = !m_busy && iv && (!lv || m_last);
    gl  = !m_busy && lv && (!iv || !m_last);
    emv = m_busy && !m_taken && !m_done;
    chk("ifu_req_ready", {31'd0, ifu_req_ready}, {31'd0, gi});
    chk("lsu_req_ready", {31'd0, lsu_req_ready}, {31'd0, gl});
    chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, emv});
    chk("ifu_resp_valid", {31'd0, ifu_resp_valid},
        {31'd0, m_done && !m_own});
    chk("lsu_resp_valid", {31'd0, lsu_resp_valid},
        {31'd0, m_done && m_own});
    chk("ifu_rdata", ifu_rdata, m_rd[0]);
    chk("lsu_rdata", lsu_rdata, m_rd[1]);
    chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
    chk("err_owner", {31'd0, err_owner}, {31'd0, m_eown});
    if (emv) begin
      chk("mem_addr", {8'd0, mem_addr}, {8'd0, m_addr});
      chk("mem_wen", {31'd0, mem_wen}, {31'd0, m_wen});
      chk("mem_mask", {28'd0, mem_mask}, {28'd0, m_mask});
      if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_done) begin
      m_busy = 0; m_taken = 0; m_done = 0;
    end else if (gi || gl) begin
      m_busy = 1; m_own = gl; m_last = gl;
      m_addr = gl ? la : ia;
      m_wen  = gl && lw;
      m_wdata = wd;
      m_mask = (gl && lw) ? mk : 4'b0000;
    end else if (m_busy && !m_taken) begin
      if (mrr) begin
        m_taken = 1; m_wait = 0;
      end
    end else if (m_busy) begin
      m_wait++;
      if (mrv) begin
        m_rd[m_own] = mrd; m_done = 1;
      end else if (m_wait == TO) begin
        m_rd[m_own] = '0; m_done = 1;
        m_err = 1; m_eown = m_own;
      end
    end
  endtask

  task automatic idle_c(input bit mrr, input bit mrv,
                        input logic [DW-1:0] mrd);
    cyc(0, '0, 0, 0, '0, '0, 4'h0, mrr, mrv, mrd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ifu, n_lsu;
    logic [3:0] seq;
    logic [31:0] r1, r2, r3;
    model_reset();
    drive_zero();
    do_reset(1);

    // Single fetch, memory answers in one cycle.
    cyc(1, 24'h000000, 0, 0, '0, '0, 4'h0, 0, 0, '0);
    chk("fetch_ready_c0", {31'd0, ifu_req_ready}, 1);
    idle_c(1, 0, '0);
    chk("fetch_mreq_c1", {27'd0, mem_req_valid, mem_mask}, 32'h10);
    idle_c(0, 1, 32'h00000413);
    idle_c(0, 0, '0);
    chk("fetch_resp_c3", {31'd0, ifu_resp_valid}, 1);
    chk("fetch_data_c3", ifu_rdata, 32'h00000413);
    idle_c(0, 0, '0);
    chk("fetch_pulse_c4", {31'd0, ifu_resp_valid}, 0);

    // Both valid after reset: IFU, LSU, IFU, LSU.
    do_reset(0);
    n_ifu = 0; n_lsu = 0; seq = '0;
    for (int i = 0; i < 16; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      cyc(1, r1[23:0], 1, r2[0], r2[31:8], r1, r2[7:4], 1, 1, r2);
      if (i == 0)
        chk("tie_first", {30'd0, lsu_req_ready, ifu_req_ready}, 1);
      if (ifu_resp_valid) begin
        n_ifu++; seq = {seq[2:0], 1'b0};
      end
      if (lsu_resp_valid) begin
        n_lsu++; seq = {seq[2:0], 1'b1};
      end
    end
    chk("tie_count", n_ifu * 16 + n_lsu, 32'h22);
    chk("tie_order", {28'd0, seq}, 32'h5);

    // Store with a three-cycle memory stall.
    do_reset(0);
    cyc(0, '0, 1, 1, 24'h000010, 32'h0000AB00, 4'b0010, 0, 0, '0);
    idle_c(0, 0, '0);
    idle_c(0, 0, '0);
    idle_c(0, 1, 32'hFFFF_FFFF);
    chk("store_addr", {8'd0, mem_addr}, 32'h10);
    chk("store_wdata", mem_wdata, 32'h0000AB00);
    chk("store_wen_mask", {27'd0, mem_wen, mem_mask}, 32'h12);
    idle_c(1, 0, '0);
    idle_c(0, 1, 32'h0);
    idle_c(0, 0, '0);
    chk("store_resp", {30'd0, lsu_resp_valid, ifu_resp_valid}, 2);
    idle_c(0, 0, '0);
    chk("store_pulse", {31'd0, lsu_resp_valid}, 0);

    // Load that never gets a response, then a fetch.
    do_reset(0);
    cyc(0, '0, 1, 0, 24'h000020, '0, 4'hF, 0, 0, '0);
    idle_c(1, 0, '0);
    for (int i = 0; i < TO; i++) idle_c(0, 0, '0);
    chk("to_no_err_yet", {31'd0, bus_err}, 0);
    cyc(1, 24'h000040, 0, 0, '0, '0, 4'h0, 0, 0, '0);
    chk("to_resp", {31'd0, lsu_resp_valid}, 1);
    chk("to_rdata", lsu_rdata, 0);
    chk("to_err", {30'd0, bus_err, err_owner}, 3);
    cyc(1, 24'h000040, 0, 0, '0, '0, 4'h0, 0, 0, '0);
    idle_c(1, 0, '0);
    idle_c(0, 1, 32'h12345678);
    idle_c(0, 0, '0);
    chk("to_fetch_resp", {31'd0, ifu_resp_valid}, 1);
    chk("to_fetch_data", ifu_rdata, 32'h12345678);
    chk("to_err_sticky", {31'd0, bus_err}, 1);

    // Asynchronous reset in WAIT, then a stale response.
    cyc(0, '0, 1, 0, 24'h000030, '0, 4'h0, 0, 0, '0);
    idle_c(1, 0, '0);
    idle_c(0, 0, '0);
    #2 rst = 1;
    #1 chk_all_zero("midwait");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle_c(0, 1, 32'hDEADBEEF);
    idle_c(0, 0, '0);
    chk("stale_none", {30'd0, lsu_resp_valid, ifu_resp_valid}, 0);
    cyc(1, 24'h000004, 0, 0, '0, '0, 4'h0, 0, 0, '0);
    chk("stale_idle", {31'd0, ifu_req_ready}, 1);
    idle_c(1, 1, 32'h0);
    idle_c(0, 1, 32'h0);
    idle_c(0, 0, '0);

    // Response in the same cycle the count reaches TIMEOUT.
    do_reset(0);
    cyc(0, '0, 1, 0, 24'h000050, '0, 4'h0, 0, 0, '0);
    idle_c(1, 0, '0);
    for (int i = 0; i < TO - 1; i++) idle_c(0, 0, '0);
    idle_c(0, 1, 32'hCAFEF00D);
    idle_c(0, 0, '0);
    chk("bnd_resp", {31'd0, lsu_resp_valid}, 1);
    chk("bnd_data", lsu_rdata, 32'hCAFEF00D);
    chk("bnd_no_err", {31'd0, bus_err}, 0);

    // Random traffic with stray responses and occasional timeouts.
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      cyc(r3[0], r1[23:0], r3[1], r3[2], r2[23:0], r1 ^ r2,
          r3[7:4], r3[8], (r3[11:10] == 2'b00), r2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
